// File: rtl/ascon_pkg.sv
// ascon_pkg
// Shared constants, state encodings and the Ascon round function used by the
// decryption controller and its permutation core.
//   STATE_W / RATE_W          : sponge state width (320) and rate width (128)
//   ROUNDS_INIT / ROUNDS_BLK  : round counts for init/final (12) and blocks (8)
//   DOMAIN_SEP                : constant XORed into S between AD and ciphertext
//   DEFAULT_IV                : Ascon-128a initialization vector
//   ctrl_state_e              : controller FSM states
//   perm_state_e              : permutation core FSM states
//   ascon_round()             : one Ascon round (constant, S-box, linear layer)
package ascon_pkg;

  localparam int STATE_W     = 320;
  localparam int RATE_W      = 128;
  localparam int ROUNDS_INIT = 12;
  localparam int ROUNDS_BLK  = 8;

  localparam logic [STATE_W-1:0] DOMAIN_SEP = 320'h1;
  localparam logic [63:0]        DEFAULT_IV = 64'h80800c0800000000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_START,
    ST_INIT_WAIT,
    ST_AD_START,
    ST_AD_WAIT,
    ST_DOMAIN,
    ST_CT0,
    ST_CT_START,
    ST_CT_WAIT,
    ST_CT1,
    ST_FIN_START,
    ST_FIN_WAIT,
    ST_VERIFY,
    ST_DONE
  } ctrl_state_e;

  typedef enum logic [1:0] {
    PERM_IDLE,
    PERM_RUN,
    PERM_DONE
  } perm_state_e;

  // idx is the absolute round index 0..11; a p^r permutation runs the last r
  // of them, so the round constant only depends on idx.
  function automatic logic [STATE_W-1:0] ascon_round(input logic [STATE_W-1:0] s,
                                                      input logic [3:0] idx);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2 = x2 ^ {56'h0, 4'hf - idx, idx};
    // Bitsliced 5-bit S-box.
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    // Linear diffusion: each word XORed with two right-rotations of itself.
    x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
    x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
    x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
    x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
    x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
    return {x0, x1, x2, x3, x4};
  endfunction

endpackage

// File: rtl/permutation.sv
// permutation
// Iterative Ascon permutation, one round per clock.
//   clk    : clock
//   rst    : asynchronous active-high reset
//   start  : level request; P_in/rounds are loaded on the first cycle it is seen
//            high in idle, and the result is held until start drops
//   P_in   : input state
//   rounds : number of rounds (1..12)
//   ready  : high while the result is available and start is still high
//   P_out  : permuted state
module permutation
  import ascon_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] P_in,
  input  logic [3:0]         rounds,
  output logic               ready,
  output logic [STATE_W-1:0] P_out
);

  perm_state_e        r_pstate;
  perm_state_e        w_next_pstate;
  logic [STATE_W-1:0] r_s;
  logic [3:0]         r_idx;

  always_comb begin
    w_next_pstate = r_pstate;
    case (r_pstate)
      PERM_IDLE: if (start) w_next_pstate = (rounds == 4'd0) ? PERM_DONE : PERM_RUN;
      PERM_RUN:  if (r_idx == 4'd11) w_next_pstate = PERM_DONE;
      PERM_DONE: if (!start) w_next_pstate = PERM_IDLE;
      default:   w_next_pstate = PERM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pstate <= PERM_IDLE;
    else     r_pstate <= w_next_pstate;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s   <= '0;
      r_idx <= '0;
    end else begin
      case (r_pstate)
        PERM_IDLE: if (start) begin
          r_s   <= P_in;
          r_idx <= 4'd12 - rounds;
        end
        PERM_RUN: begin
          r_s   <= ascon_round(r_s, r_idx);
          r_idx <= r_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign ready = (r_pstate == PERM_DONE);
  assign P_out = r_s;

endmodule

// File: rtl/decryption_controller.sv
// decryption_controller
// Ascon-style authenticated decryption of two AD blocks and a two-block
// ciphertext; plaintext is released only when the recomputed tag matches.
//   clk, rst_n        : clock, asynchronous active-low reset
//   IV, key, nonce    : initialization inputs (snapshotted at start)
//   associated_data   : A0 = [255:128], A1 = [127:0]
//   cipher_text       : C0 = [255:128], C1 = [127:0]
//   tag_in            : received tag
//   decryption_start  : level request, accepted in IDLE and DONE
//   plain_text        : {P0, P1} when tag_valid, otherwise 0
//   tag_valid         : computed tag equals tag_in
//   decryption_ready  : high while in DONE
//   busy              : high in every state other than IDLE and DONE
module decryption_controller
  import ascon_pkg::*;
#(
  parameter int ROUNDS_A = ROUNDS_INIT,
  parameter int ROUNDS_B = ROUNDS_BLK
)
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [63:0]  IV,
  input  logic [127:0] key,
  input  logic [127:0] nonce,
  input  logic [255:0] associated_data,
  input  logic [255:0] cipher_text,
  input  logic [127:0] tag_in,
  input  logic         decryption_start,
  output logic [255:0] plain_text,
  output logic         tag_valid,
  output logic         decryption_ready,
  output logic         busy
);

  localparam logic [3:0] RA = 4'(ROUNDS_A);
  localparam logic [3:0] RB = 4'(ROUNDS_B);

  ctrl_state_e        r_state;
  ctrl_state_e        w_next_state;
  logic [127:0]       r_key;
  logic [127:0]       r_tag;
  logic [255:0]       r_ad;
  logic [255:0]       r_ct;
  logic [STATE_W-1:0] r_s;
  logic [STATE_W-1:0] r_p_in;
  logic [RATE_W-1:0]  r_p0;
  logic [RATE_W-1:0]  r_p1;
  logic [3:0]         r_rounds;
  logic               r_start;
  logic               r_ad_cnt;
  logic [255:0]       r_plain;
  logic               r_tag_valid;
  logic               r_ready;

  logic               w_perm_rst;
  logic               w_perm_ready;
  logic [STATE_W-1:0] w_perm_out;
  logic               w_perm_done;
  logic [RATE_W-1:0]  w_ad_blk;
  logic [127:0]       w_tag;

  assign w_perm_rst  = ~rst_n;
  // ready is only meaningful for the permutation this controller launched.
  assign w_perm_done = r_start & w_perm_ready;
  assign w_ad_blk    = r_ad_cnt ? r_ad[127:0] : r_ad[255:128];
  assign w_tag       = r_s[319:192] ^ r_key;

  permutation u_perm (
    .clk    (clk),
    .rst    (w_perm_rst),
    .start  (r_start),
    .P_in   (r_p_in),
    .rounds (r_rounds),
    .ready  (w_perm_ready),
    .P_out  (w_perm_out)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (decryption_start) w_next_state = ST_INIT_START;
      ST_INIT_START:    w_next_state = ST_INIT_WAIT;
      ST_INIT_WAIT:     if (w_perm_done) w_next_state = ST_AD_START;
      ST_AD_START:      w_next_state = ST_AD_WAIT;
      ST_AD_WAIT:       if (w_perm_done) w_next_state = r_ad_cnt ? ST_DOMAIN : ST_AD_START;
      ST_DOMAIN:        w_next_state = ST_CT0;
      ST_CT0:           w_next_state = ST_CT_START;
      ST_CT_START:      w_next_state = ST_CT_WAIT;
      ST_CT_WAIT:       if (w_perm_done) w_next_state = ST_CT1;
      ST_CT1:           w_next_state = ST_FIN_START;
      ST_FIN_START:     w_next_state = ST_FIN_WAIT;
      ST_FIN_WAIT:      if (w_perm_done) w_next_state = ST_VERIFY;
      ST_VERIFY:        w_next_state = ST_DONE;
      default:          w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // start is registered so it is low during every *_START cycle, which gives
  // the core the idle cycle it needs between back-to-back permutations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key       <= '0;
      r_tag       <= '0;
      r_ad        <= '0;
      r_ct        <= '0;
      r_s         <= '0;
      r_p_in      <= '0;
      r_p0        <= '0;
      r_p1        <= '0;
      r_rounds    <= '0;
      r_start     <= 1'b0;
      r_ad_cnt    <= 1'b0;
      r_plain     <= '0;
      r_tag_valid <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (decryption_start) begin
          r_key       <= key;
          r_tag       <= tag_in;
          r_ad        <= associated_data;
          r_ct        <= cipher_text;
          r_s         <= {IV, key, nonce};
          r_ad_cnt    <= 1'b0;
          r_plain     <= '0;
          r_tag_valid <= 1'b0;
          r_ready     <= 1'b0;
        end
        ST_INIT_START: begin
          r_p_in   <= r_s;
          r_rounds <= RA;
          r_start  <= 1'b1;
        end
        ST_INIT_WAIT: if (w_perm_done) begin
          r_s     <= w_perm_out ^ {192'b0, r_key};
          r_start <= 1'b0;
        end
        ST_AD_START: begin
          r_p_in   <= {r_s[127:0] ^ w_ad_blk, r_s[319:128]};
          r_rounds <= RB;
          r_start  <= 1'b1;
        end
        ST_AD_WAIT: if (w_perm_done) begin
          r_s      <= w_perm_out;
          r_start  <= 1'b0;
          r_ad_cnt <= ~r_ad_cnt;
        end
        ST_DOMAIN: r_s <= r_s ^ DOMAIN_SEP;
        ST_CT0: begin
          r_p0        <= r_s[127:0] ^ r_ct[255:128];
          r_s[127:0]  <= r_ct[255:128];
        end
        ST_CT_START: begin
          r_p_in   <= r_s;
          r_rounds <= RB;
          r_start  <= 1'b1;
        end
        ST_CT_WAIT: if (w_perm_done) begin
          r_s     <= w_perm_out;
          r_start <= 1'b0;
        end
        ST_CT1: begin
          r_p1       <= r_s[127:0] ^ r_ct[127:0];
          r_s[127:0] <= r_ct[127:0];
        end
        ST_FIN_START: begin
          r_p_in   <= r_s ^ {128'b0, r_key, 64'b0};
          r_rounds <= RA;
          r_start  <= 1'b1;
        end
        ST_FIN_WAIT: if (w_perm_done) begin
          r_s     <= w_perm_out;
          r_start <= 1'b0;
        end
        ST_VERIFY: begin
          r_ready <= 1'b1;
          if (w_tag == r_tag) begin
            r_tag_valid <= 1'b1;
            r_plain     <= {r_p0, r_p1};
          end
        end
        default: ;
      endcase
    end
  end

  assign plain_text       = r_plain;
  assign tag_valid        = r_tag_valid;
  assign decryption_ready = r_ready;
  assign busy             = (r_state != ST_IDLE) && (r_state != ST_DONE);

endmodule

// File: tb/tb_decryption_controller.sv
module tb_decryption_controller;

  // 9 single-cycle states; each wait state costs rounds + 2 cycles.
  localparam int LAT = 9 + 2 * (12 + 2) + 3 * (8 + 2);

  localparam logic [63:0]  IV0 = 64'h80800c0800000000;
  localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] N0  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] N1  = 128'h202122232425262728292a2b2c2d2e2f;
  localparam logic [255:0] AD0 = 256'h1;
  localparam logic [255:0] PT0 = {8{32'hdeadbeef}};

  // Ascon S-box lookup table, entry i at [5*i +: 5], input bit 4 = word x0.
  localparam logic [159:0] SBOX_TBL = {
    5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
    5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
    5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
    5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04};

  logic         clk;
  logic         rst_n;
  logic [63:0]  IV;
  logic [127:0] key;
  logic [127:0] nonce;
  logic [255:0] associated_data;
  logic [255:0] cipher_text;
  logic [127:0] tag_in;
  logic         decryption_start;
  logic [255:0] plain_text;
  logic         tag_valid;
  logic         decryption_ready;
  logic         busy;

  typedef struct packed {
    logic [7:0]   id;
    logic [255:0] pt;
    logic         v;
    logic         b2b;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  decryption_controller dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .IV               (IV),
    .key              (key),
    .nonce            (nonce),
    .associated_data  (associated_data),
    .cipher_text      (cipher_text),
    .tag_in           (tag_in),
    .decryption_start (decryption_start),
    .plain_text       (plain_text),
    .tag_valid        (tag_valid),
    .decryption_ready (decryption_ready),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [4:0] sbox(input logic [4:0] i);
    return SBOX_TBL[5 * int'(i) +: 5];
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] m_perm(input logic [319:0] s_in, input int nr);
    logic [63:0] x [5];
    logic [4:0]  v;
    for (int w = 0; w < 5; w++) x[w] = s_in[319 - 64 * w -: 64];
    for (int r = 12 - nr; r < 12; r++) begin
      x[2] = x[2] ^ 64'((15 - r) * 16 + r);
      for (int b = 0; b < 64; b++) begin
        v = sbox({x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]});
        x[0][b] = v[4];
        x[1][b] = v[3];
        x[2][b] = v[2];
        x[3][b] = v[1];
        x[4][b] = v[0];
      end
      x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
      x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
      x[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
      x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
      x[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  // dec=0: blk is plaintext, out is ciphertext; dec=1: the reverse.
  task automatic m_run(input logic [63:0] iv, input logic [127:0] k, input logic [127:0] n,
                       input logic [255:0] ad, input logic [255:0] blk, input logic dec,
                       output logic [255:0] out, output logic [127:0] tg);
    logic [319:0] s;
    logic [127:0] a, o0, o1;
    s = {iv, k, n};
    s = m_perm(s, 12) ^ {192'b0, k};
    for (int j = 0; j < 2; j++) begin
      a = (j == 0) ? ad[255:128] : ad[127:0];
      s = m_perm({s[127:0] ^ a, s[319:128]}, 8);
    end
    s = s ^ 320'h1;
    o0 = s[127:0] ^ blk[255:128];
    s[127:0] = dec ? blk[255:128] : o0;
    s = m_perm(s, 8);
    o1 = s[127:0] ^ blk[127:0];
    s[127:0] = dec ? blk[127:0] : o1;
    s = m_perm(s ^ {128'b0, k, 64'b0}, 12);
    tg = s[319:192] ^ k;
    out = {o0, o1};
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic wait_done(input int target);
    int cyc = 0;
    while (done_cnt < target && cyc < 400) begin
      @(posedge clk);
      cyc++;
    end
    if (done_cnt < target) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL timeout: done count %0d, expected %0d", done_cnt, target);
    end
  endtask

  task automatic run_vec(input logic [7:0] id, input logic [127:0] k, input logic [127:0] n,
                         input logic [255:0] ad, input logic [255:0] ct, input logic [127:0] tg,
                         input logic [255:0] ep, input logic ev);
    int target;
    @(posedge clk); #1;
    IV = IV0; key = k; nonce = n; associated_data = ad; cipher_text = ct; tag_in = tg;
    decryption_start = 1'b1;
    sb_q.push_back(exp_t'{id, ep, ev, 1'b0});
    target = done_cnt + 1;
    @(posedge clk); #1;
    decryption_start = 1'b0;
    wait_done(target);
    repeat (2) @(posedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic prev;
    int   busy_cnt;
    exp_t e;
    prev = 1'b0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (decryption_ready && !prev) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL unexpected_done: got ready=1, expected no result");
          end else begin
            e = sb_q.pop_front();
            $display("[TB] run %0d: tag_valid=%0b plain=%h cycles=%0d",
                     e.id, tag_valid, plain_text, busy_cnt);
            check($sformatf("run%0d plain_text", e.id), plain_text, e.pt);
            check($sformatf("run%0d tag_valid", e.id), 256'(tag_valid), 256'(e.v));
            check($sformatf("run%0d latency", e.id), 256'(busy_cnt), 256'(LAT));
            busy_cnt = 0;
            done_cnt++;
            @(negedge clk);
            if (e.b2b) begin
              check($sformatf("run%0d done_width", e.id), 256'(decryption_ready), 256'(0));
              check($sformatf("run%0d plain_cleared", e.id), plain_text, 256'(0));
            end else begin
              check($sformatf("run%0d ready_hold", e.id), 256'(decryption_ready), 256'(1));
              check($sformatf("run%0d plain_hold", e.id), plain_text, e.pt);
            end
            if (busy) busy_cnt++;
          end
        end
        prev = decryption_ready;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] ct, ct1, zp;
    logic [127:0] tg, tg1, zt;
    int target;

    rst_n = 1'b0;
    IV = '0; key = '0; nonce = '0; associated_data = '0; cipher_text = '0; tag_in = '0;
    decryption_start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset plain_text", plain_text, 256'(0));
    check("reset tag_valid", 256'(tag_valid), 256'(0));
    check("reset ready", 256'(decryption_ready), 256'(0));
    check("reset busy", 256'(busy), 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    m_run(IV0, K0, N0, AD0, PT0, 1'b0, ct, tg);

    // Round trip, corrupted tag, corrupted C0 bit 0.
    run_vec(8'd1, K0, N0, AD0, ct, tg, PT0, 1'b1);
    run_vec(8'd2, K0, N0, AD0, ct, tg ^ 128'h1, 256'h0, 1'b0);
    run_vec(8'd3, K0, N0, AD0, ct ^ (256'h1 << 128), tg, 256'h0, 1'b0);

    // All-zero key/nonce/AD/ciphertext/tag against the model.
    m_run(IV0, 128'h0, 128'h0, 256'h0, 256'h0, 1'b1, zp, zt);
    run_vec(8'd4, 128'h0, 128'h0, 256'h0, 256'h0, 128'h0,
            (zt == 128'h0) ? zp : 256'h0, zt == 128'h0);

    // Reset asserted during the first AD permutation.
    @(posedge clk); #1;
    key = K0; nonce = N0; associated_data = AD0; cipher_text = ct; tag_in = tg;
    decryption_start = 1'b1;
    @(posedge clk); #1;
    decryption_start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("midrun busy_before_reset", 256'(busy), 256'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrun busy_in_reset", 256'(busy), 256'(0));
    check("midrun plain_in_reset", plain_text, 256'(0));
    check("midrun valid_in_reset", 256'(tag_valid), 256'(0));
    check("midrun ready_in_reset", 256'(decryption_ready), 256'(0));
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrun idle_after_reset", 256'({busy, decryption_ready, tag_valid}), 256'(0));
    check("midrun plain_after_reset", plain_text, 256'(0));

    run_vec(8'd5, K0, N0, AD0, ct, tg, PT0, 1'b1);

    // Back-to-back: start held high across two runs with different nonces.
    m_run(IV0, K0, N1, AD0, PT0, 1'b0, ct1, tg1);
    @(posedge clk); #1;
    key = K0; nonce = N0; associated_data = AD0; cipher_text = ct; tag_in = tg;
    decryption_start = 1'b1;
    sb_q.push_back(exp_t'{8'd6, PT0, 1'b1, 1'b1});
    target = done_cnt + 1;
    repeat (5) @(posedge clk); #1;
    nonce = N1; cipher_text = ct1; tag_in = tg1;
    sb_q.push_back(exp_t'{8'd7, PT0, 1'b1, 1'b0});
    wait_done(target);
    #1;
    decryption_start = 1'b0;
    wait_done(target + 1);
    repeat (3) @(posedge clk);

    check("scoreboard_empty", 256'(sb_q.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
